// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button events to count enable, clear and lap freeze.
// Also selects the BCD word driven to the 4-digit display.
module stopwatch_ctrl #(
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          STOP_ON_OVF = 1'b1,
  parameter logic [15:0] OVF_DISP    = 16'h9999
) (
  input  logic        clk,
  input  logic        RESET_n,
  input  logic        ce1ms,
  input  logic        ss_p,
  input  logic        lap_lvl,
  input  logic [15:0] time_in,
  input  logic        ovf,
  output logic        EN,
  output logic        CLR,
  output logic [15:0] disp_dat,
  output logic        lap_act,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_OVF   = 3'd4
  } state_e;

  localparam logic [15:0] LONG_V = 16'(LONG_MS);
  localparam logic [15:0] LAST_V = 16'(LONG_MS - 1);

  state_e      st_q, st_d;
  logic [15:0] hold_q, hold_d;
  logic        lap_dly_q;
  logic [15:0] lap_q, lap_d;
  logic [15:0] disp_q, disp_d;
  logic        en_q, en_d;
  logic        clr_q, clr_d;
  logic        lact_q, lact_d;

  logic        long_ev;
  logic        short_ev;
  logic        ovf_ev;
  logic        running;

  // Press length in ms; saturates so a long press fires only once.
  always_comb begin
    hold_d = hold_q;
    if (!lap_lvl) begin
      hold_d = '0;
    end else if (ce1ms && (hold_q < LONG_V)) begin
      hold_d = hold_q + 16'd1;
    end
  end

  assign running  = (st_q == S_RUN) || (st_q == S_LAP);
  assign long_ev  = lap_lvl & ce1ms & (hold_q == LAST_V);
  assign short_ev = lap_dly_q & ~lap_lvl & (hold_q < LONG_V);
  assign ovf_ev   = STOP_ON_OVF & ovf & running;

  always_comb begin
    st_d  = st_q;
    lap_d = lap_q;
    if (long_ev) begin
      st_d = S_IDLE;
    end else if (ovf_ev) begin
      st_d = S_OVF;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (ss_p) st_d = S_RUN;
        end
        S_RUN: begin
          if (ss_p) begin
            st_d = S_PAUSE;
          end else if (short_ev) begin
            st_d  = S_LAP;
            lap_d = time_in;
          end
        end
        S_LAP: begin
          if (ss_p) begin
            st_d = S_PAUSE;
          end else if (short_ev) begin
            st_d = S_RUN;
          end
        end
        S_PAUSE: begin
          if (ss_p) st_d = S_RUN;
        end
        S_OVF: begin
          st_d = S_OVF;
        end
        default: begin
          st_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with state.
  always_comb begin
    en_d   = (st_d == S_RUN) || (st_d == S_LAP);
    clr_d  = long_ev;
    lact_d = (st_d == S_LAP);
    disp_d = time_in;
    unique case (1'b1)
      (st_d == S_LAP): disp_d = lap_d;
      (st_d == S_OVF): disp_d = OVF_DISP;
      default:         disp_d = time_in;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      st_q      <= S_IDLE;
      hold_q    <= '0;
      lap_dly_q <= 1'b0;
      lap_q     <= '0;
      disp_q    <= '0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      lact_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      hold_q    <= hold_d;
      lap_dly_q <= lap_lvl;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      en_q      <= en_d;
      clr_q     <= clr_d;
      lact_q    <= lact_d;
    end
  end

  assign EN       = en_q;
  assign CLR      = clr_q;
  assign disp_dat = disp_q;
  assign lap_act  = lact_q;
  assign state    = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two configurations against a behavioural model.
// Directed scenarios pin the model; a random phase follows.
module tb_stopwatch_ctrl;

  localparam int L0 = 1000;
  localparam int L1 = 8;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3, OVF = 4;

  logic        clk = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ce1ms = 1'b0;
  logic        ss_p = 1'b0;
  logic        lap_lvl = 1'b0;
  logic        ovf = 1'b0;
  logic [15:0] time_in = '0;
  bit          tin_hold = 1'b0;

  logic [1:0]  en_o, clr_o, la_o;
  logic [2:0]  st_o [2];
  logic [15:0] dd_o [2];

  int cmp_n = 0;
  int err_n = 0;

  int          m_st   [2] = '{0, 0};
  int          m_held [2] = '{0, 0};
  bit          m_prev [2] = '{0, 0};
  bit          m_clr  [2] = '{0, 0};
  logic [15:0] m_disp [2] = '{16'h0, 16'h0};
  logic [15:0] m_lapv [2] = '{16'h0, 16'h0};

  always #5 clk = ~clk;

  stopwatch_ctrl #(.LONG_MS(L0)) u0 (
    .clk(clk), .RESET_n(RESET_n), .ce1ms(ce1ms), .ss_p(ss_p),
    .lap_lvl(lap_lvl), .time_in(time_in), .ovf(ovf),
    .EN(en_o[0]), .CLR(clr_o[0]), .disp_dat(dd_o[0]),
    .lap_act(la_o[0]), .state(st_o[0])
  );

  stopwatch_ctrl #(.LONG_MS(L1), .STOP_ON_OVF(1'b0)) u1 (
    .clk(clk), .RESET_n(RESET_n), .ce1ms(ce1ms), .ss_p(ss_p),
    .lap_lvl(lap_lvl), .time_in(time_in), .ovf(ovf),
    .EN(en_o[1]), .CLR(clr_o[1]), .disp_dat(dd_o[1]),
    .lap_act(la_o[1]), .state(st_o[1])
  );

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  // Behavioural reference: ms held per press, prioritised events.
  task automatic model_step(input int k);
    int lim;
    int nh;
    bit stop, lg, sh, ov;
    int ns;
    lim  = (k == 0) ? L0 : L1;
    stop = (k == 0);
    if (!lap_lvl) nh = 0;
    else if (ce1ms && m_held[k] < lim) nh = m_held[k] + 1;
    else nh = m_held[k];
    lg = lap_lvl && (nh == lim) && (m_held[k] != lim);
    sh = m_prev[k] && !lap_lvl && (m_held[k] < lim);
    ov = ovf && stop && (m_st[k] == RUN || m_st[k] == LAP);
    ns = m_st[k];
    if (lg) ns = IDLE;
    else if (ov) ns = OVF;
    else if (ss_p) begin
      if (m_st[k] == IDLE || m_st[k] == PAUSE) ns = RUN;
      else if (m_st[k] == RUN || m_st[k] == LAP) ns = PAUSE;
    end else if (sh) begin
      if (m_st[k] == RUN) begin
        ns = LAP;
        m_lapv[k] = time_in;
      end else if (m_st[k] == LAP) begin
        ns = RUN;
      end
    end
    m_clr[k] = lg;
    if (ns == LAP) m_disp[k] = m_lapv[k];
    else if (ns == OVF) m_disp[k] = 16'h9999;
    else m_disp[k] = time_in;
    m_st[k]   = ns;
    m_held[k] = nh;
    m_prev[k] = lap_lvl;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge RESET_n);
      for (int k = 0; k < 2; k++) begin
        if (!RESET_n) begin
          m_st[k] = IDLE; m_held[k] = 0; m_prev[k] = 0;
          m_clr[k] = 0; m_disp[k] = '0; m_lapv[k] = '0;
        end else begin
          model_step(k);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("state", k, st_o[k], m_st[k]);
        chk("EN", k, en_o[k], (m_st[k] == RUN || m_st[k] == LAP));
        chk("CLR", k, clr_o[k], m_clr[k]);
        chk("lap_act", k, la_o[k], (m_st[k] == LAP));
        chk("disp_dat", k, dd_o[k], m_disp[k]);
      end
    end
  end

  task automatic step(input bit s, input bit o, input bit c, input bit l);
    @(posedge clk);
    #1;
    ss_p = s; ovf = o; ce1ms = c; lap_lvl = l;
    if (!tin_hold) time_in = 16'($urandom);
  endtask

  task automatic short_press(input int n, input bit ss_rel);
    for (int i = 0; i < n; i++) step(0, 0, 1, 1);
    step(ss_rel, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic long_press(input bit ss_last);
    for (int i = 0; i < L0; i++) step((i == L0 - 1) ? ss_last : 1'b0, 0, 1, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    bit lp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 0, st_o[0], 0);
    chk("rst_en", 0, en_o[0], 0);
    chk("rst_disp", 0, dd_o[0], 0);
    RESET_n = 1'b1;
    repeat (8) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("start_state", 0, st_o[0], RUN);
    chk("start_en", 0, en_o[0], 1);
    repeat (38) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("stop_state", 0, st_o[0], PAUSE);
    chk("stop_en", 0, en_o[0], 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Lap freeze on 0x1234 while time keeps moving.
    tin_hold = 1'b1;
    time_in  = 16'h1234;
    short_press(5, 0);
    chk("lap_state", 0, st_o[0], LAP);
    chk("lap_act", 0, la_o[0], 1);
    tin_hold = 1'b0;
    repeat (4) step(0, 0, 0, 0);
    chk("lap_hold", 0, dd_o[0], 16'h1234);
    short_press(2, 0);
    chk("unlap_state", 0, st_o[0], RUN);
    chk("unlap_act", 0, la_o[0], 0);

    // Long press in PAUSE clears; release is silent.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    long_press(0);
    chk("long_state", 0, st_o[0], IDLE);
    chk("long_clr", 0, clr_o[0], 1);
    step(0, 0, 0, 1);
    chk("clr_once", 0, clr_o[0], 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rel_silent", 0, st_o[0], IDLE);

    // Overflow stops one config, ignored by the other.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("ovf_state", 0, st_o[0], OVF);
    chk("ovf_en", 0, en_o[0], 0);
    chk("ovf_disp", 0, dd_o[0], 16'h9999);
    chk("ovf_ignored", 1, st_o[1], RUN);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("ovf_ss", 0, st_o[0], OVF);
    short_press(3, 0);
    chk("ovf_short", 0, st_o[0], OVF);
    long_press(0);
    chk("ovf_exit", 0, st_o[0], IDLE);
    chk("ovf_clr", 0, clr_o[0], 1);
    step(0, 0, 0, 0);

    // Same-clock collisions.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("ss_ovf", 0, st_o[0], OVF);
    long_press(0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    short_press(3, 1);
    chk("ss_short", 0, st_o[0], PAUSE);
    chk("ss_short_act", 0, la_o[0], 0);
    long_press(1);
    chk("long_ss", 0, st_o[0], IDLE);
    chk("long_ss_clr", 0, clr_o[0], 1);
    step(0, 0, 0, 0);

    // Asynchronous reset in LAP, then a long press held across release.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    short_press(3, 0);
    chk("pre_rst_lap", 0, st_o[0], LAP);
    #2;
    RESET_n = 1'b0;
    lap_lvl = 1'b1;
    #1;
    chk("arst_state", 0, st_o[0], 0);
    chk("arst_en", 0, en_o[0], 0);
    chk("arst_act", 0, la_o[0], 0);
    chk("arst_disp", 0, dd_o[0], 0);
    chk("arst_clr", 0, clr_o[0], 0);
    #1;
    RESET_n = 1'b1;
    long_press(0);
    chk("rst_long_clr", 0, clr_o[0], 1);
    repeat (20) step(0, 0, 1, 1);
    chk("rst_long_once", 0, clr_o[0], 0);
    step(0, 0, 0, 0);

    // Random phase.
    lp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) lp = !lp;
      step($urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0,
           1'($urandom_range(0, 1)), lp);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
